osd_vram_ctrl: RTL and testbench

- Owns the single-port OSD video RAM (RGB332, one byte per OSD pixel) and arbitrates it between display fetch and a host write stream.
- Display side takes osd_x/osd_y from the OSD window block and returns 8-bit R/G/B plus an enable, which feed that block's OSD colour inputs.
- Host writes (from the SPI/CPU side) are buffered in a small FIFO and retired only in cycles the display does not own the port.

---
 rtl/osd_vram_ctrl.sv | 141 ++++++++++++++
 tb/tb_osd_vram_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/osd_vram_ctrl.sv
// osd_vram_ctrl: single-port RGB332 OSD video RAM shared by display fetch (priority) and a FIFO-buffered host write stream.
// Optional clear engine: define OSD_VRAM_CLEAR_EN to add i_clear/o_busy and the fill FSM.
module osd_vram_ctrl #(
    parameter int          C_x_addr_bits     = 6,
    parameter int          C_y_addr_bits     = 6,
    parameter int          C_fifo_depth_log2 = 2,
    parameter logic [7:0]  C_fill_value      = 8'h00
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset,
    input  logic                                 clk_pixel_ena,
    input  logic                                 i_disp_active,
    input  logic [C_x_addr_bits-1:0]             i_osd_x,
    input  logic [C_y_addr_bits-1:0]             i_osd_y,
    input  logic                                 i_wr_valid,
    input  logic [C_x_addr_bits+C_y_addr_bits-1:0] i_wr_addr,
    input  logic [7:0]                           i_wr_data,
`ifdef OSD_VRAM_CLEAR_EN
    input  logic                                 i_clear,
    output logic                                 o_busy,
`endif
    output logic                                 o_wr_ready,
    output logic                                 o_wr_overrun,
    output logic                                 o_osd_en,
    output logic [7:0]                           o_osd_r,
    output logic [7:0]                           o_osd_g,
    output logic [7:0]                           o_osd_b
);
    localparam int AW = C_x_addr_bits + C_y_addr_bits;
    localparam int L  = C_fifo_depth_log2;
    localparam int D  = 1 << L;
    typedef logic [L:0]   cnt_t;
    typedef logic [L-1:0] ptr_t;
    localparam cnt_t C_DEPTH = cnt_t'(D);

    logic [7:0]    mem_q [2**AW];
    logic [7:0]    rd_q;
    logic          act_q;
    logic [AW-1:0] fifo_a_q [D];
    logic [7:0]    fifo_d_q [D];
    ptr_t          wp_q, rp_q;
    cnt_t          cnt_q, cnt_d;
    logic          disp_slot, host_slot, push, pop, we;
    logic          fill_we, block_d;
    logic [AW-1:0] fill_addr, waddr;
    logic [7:0]    wdata;

    assign disp_slot = clk_pixel_ena & i_disp_active;
    assign host_slot = ~disp_slot & ~reset;
    assign push      = i_wr_valid & o_wr_ready;
    assign pop       = host_slot & (cnt_q != '0);
    assign cnt_d     = cnt_q + cnt_t'(push) - cnt_t'(pop);
    assign we        = pop | fill_we;
    assign waddr     = pop ? fifo_a_q[rp_q] : fill_addr;
    assign wdata     = pop ? fifo_d_q[rp_q] : C_fill_value;

`ifdef OSD_VRAM_CLEAR_EN
    typedef enum logic {S_IDLE, S_FILL} state_t;
    state_t        st_q;
    logic [AW-1:0] clr_q;
    logic          start;

    assign start     = (st_q == S_IDLE) & i_clear;
    assign fill_we   = (st_q == S_FILL) & host_slot & (cnt_q == '0);
    assign fill_addr = clr_q;
    assign block_d   = start | ((st_q == S_FILL) & ~(fill_we & (&clr_q)));

    // Clear FSM: sweep every address once with the fill byte, yielding to the FIFO and the display
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            st_q   <= S_IDLE;
            clr_q  <= '0;
            o_busy <= 1'b0;
        end else if (start) begin
            st_q   <= S_FILL;
            clr_q  <= '0;
            o_busy <= 1'b1;
        end else if (fill_we) begin
            clr_q <= clr_q + 1'b1;
            if (&clr_q) begin
                st_q   <= S_IDLE;
                o_busy <= 1'b0;
            end
        end
    end
`else
    assign fill_we   = 1'b0;
    assign fill_addr = '0;
    assign block_d   = 1'b0;
`endif

    // Single RAM port: display read has priority, otherwise one host/fill write
    always_ff @(posedge clk_pixel) begin
        if (disp_slot)
            rd_q <= mem_q[{i_osd_y, i_osd_x}];
        else if (we)
            mem_q[waddr] <= wdata;
    end

    // FIFO storage, written on accepted pushes
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_a_q[wp_q] <= i_wr_addr;
            fifo_d_q[wp_q] <= i_wr_data;
        end
    end

    // FIFO pointers, occupancy, registered ready and sticky overrun
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= '0;
            o_wr_ready   <= 1'b0;
            o_wr_overrun <= 1'b0;
        end else begin
            wp_q         <= wp_q + ptr_t'(push);
            rp_q         <= rp_q + ptr_t'(pop);
            cnt_q        <= cnt_d;
            o_wr_ready   <= (cnt_d < C_DEPTH) & ~block_d;
            o_wr_overrun <= o_wr_overrun | (i_wr_valid & ~o_wr_ready);
        end
    end

    // Display pipeline: stage-1 active flag, stage-2 RGB332 expansion into output registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            act_q    <= 1'b0;
            o_osd_en <= 1'b0;
            o_osd_r  <= '0;
            o_osd_g  <= '0;
            o_osd_b  <= '0;
        end else if (clk_pixel_ena) begin
            act_q    <= i_disp_active;
            o_osd_en <= act_q;
            o_osd_r  <= act_q ? {rd_q[7:5], rd_q[7:5], rd_q[7:6]} : 8'h00;
            o_osd_g  <= act_q ? {rd_q[4:2], rd_q[4:2], rd_q[4:3]} : 8'h00;
            o_osd_b  <= act_q ? {4{rd_q[1:0]}} : 8'h00;
        end
    end
endmodule

// File: tb/tb_osd_vram_ctrl.sv
// tb_osd_vram_ctrl: directed and random checks of osd_vram_ctrl against a queue/array reference model.
module tb_osd_vram_ctrl;
    logic clk = 1'b0, rst, ena, act, valid;
    logic [5:0] x, y;
    logic [11:0] waddr;
    logic [7:0] wdata;
    logic ready, ovr, en;
    logic [7:0] r, g, b;
`ifdef OSD_VRAM_CLEAR_EN
    logic clear, busy;
`endif
    int checks = 0, fails = 0;

    logic [19:0] q [$];
    logic [7:0]  mem_m [4096];
    bit          known_m [4096];
    bit          ready_m, ovr_m, s1_act, s1_known, en_m, known_o, chk_host;
    logic [7:0]  s1_d, r_m, g_m, b_m;

    osd_vram_ctrl #(.C_fill_value(8'h03)) dut (
        .clk_pixel(clk), .reset(rst), .clk_pixel_ena(ena), .i_disp_active(act),
        .i_osd_x(x), .i_osd_y(y), .i_wr_valid(valid), .i_wr_addr(waddr), .i_wr_data(wdata),
`ifdef OSD_VRAM_CLEAR_EN
        .i_clear(clear), .o_busy(busy),
`endif
        .o_wr_ready(ready), .o_wr_overrun(ovr), .o_osd_en(en),
        .o_osd_r(r), .o_osd_g(g), .o_osd_b(b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 3-bit channel to 8 bits is round(v*255/7); 2-bit channel is v*85
    function automatic logic [7:0] exp3(input int v);
        return 8'((v * 510 + 7) / 14);
    endfunction

    task automatic tick();
        bit ds;
        int ra;
        ds = ena & act;
        ra = int'({y, x});
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ready_m = 0; ovr_m = 0; s1_act = 0; en_m = 0;
            r_m = 0; g_m = 0; b_m = 0; known_o = 1;
        end else begin
            if (ena) begin
                en_m = s1_act;
                known_o = s1_known;
                r_m = s1_act ? exp3(int'(s1_d) / 32) : 8'h00;
                g_m = s1_act ? exp3((int'(s1_d) / 4) % 8) : 8'h00;
                b_m = s1_act ? 8'((int'(s1_d) % 4) * 85) : 8'h00;
                s1_act = act;
                if (ds) begin
                    s1_known = known_m[ra];
                    s1_d = mem_m[ra];
                end
            end
            if (!ds && q.size() > 0) begin
                mem_m[int'(q[0][19:8])] = q[0][7:0];
                known_m[int'(q[0][19:8])] = 1;
                void'(q.pop_front());
            end
            if (valid && ready_m) q.push_back({waddr, wdata});
            else if (valid) ovr_m = 1;
            ready_m = q.size() < 4;
        end
        if (chk_host) chk("ready", ready, ready_m);
        chk("overrun", ovr, ovr_m);
        chk("osd_en", en, en_m);
        if (!en_m || known_o) begin
            chk("osd_r", r, r_m);
            chk("osd_g", g, g_m);
            chk("osd_b", b, b_m);
        end
    endtask

    task automatic write1(input logic [11:0] a, input logic [7:0] d);
        valid = 1; waddr = a; wdata = d;
        tick();
        valid = 0;
    endtask

    initial begin
        rst = 1; ena = 1; act = 0; valid = 0; x = 0; y = 0; waddr = 0; wdata = 0;
        chk_host = 1; s1_known = 0;
`ifdef OSD_VRAM_CLEAR_EN
        clear = 0;
`endif
        tick(); tick();
        rst = 0;
        tick();
        chk("ready_after_reset", ready, 1);
        // Write E0 at (1,1) then display it
        write1(12'h041, 8'hE0);
        tick();
        x = 1; y = 1; act = 1;
        tick();
        act = 0;
        tick();
        chk("e0_en", en, 1); chk("e0_r", r, 8'hFF); chk("e0_g", g, 0); chk("e0_b", b, 0);
        // Fill FIFO while display owns every cycle, then overrun
        act = 1; ena = 1; x = 0; y = 0;
        for (int i = 0; i < 4; i++) write1(12'h100 + 12'(i), 8'($urandom));
        chk("full_ready", ready, 0);
        write1(12'h1FF, 8'hAA);
        chk("overrun_set", ovr, 1);
        act = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("drained_ready", ready, 1);
        act = 1; y = 4;
        for (int i = 0; i < 4; i++) begin x = 6'(i); tick(); end
        act = 0; tick(); tick();
        // Byte 1C displayed with ena every other cycle while host writes trickle in
        write1(12'h085, 8'h1C);
        tick();
        x = 5; y = 2; act = 1;
        for (int i = 0; i < 16; i++) begin
            ena = i[0];
            valid = (i < 6); waddr = 12'h200 + 12'(i); wdata = 8'($urandom);
            tick();
        end
        valid = 0;
        chk("1c_en", en, 1); chk("1c_g", g, 8'hFF); chk("1c_r", r, 0); chk("1c_b", b, 0);
        ena = 1; act = 0;
        for (int i = 0; i < 6; i++) tick();
        // Simultaneous push and pop at count 2
        act = 1;
        write1(12'h300, 8'h11);
        write1(12'h301, 8'h22);
        act = 0;
        write1(12'h302, 8'h33);
        chk("pushpop_ready", ready, 1);
        chk("pushpop_count", q.size(), 2);
        tick(); tick(); tick();
        // Random traffic confined to an 8x8 region after a reset (RAM survives reset)
        rst = 1; tick(); rst = 0; tick();
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++) write1({6'(yy), 6'(xx)}, 8'($urandom));
        tick();
        for (int i = 0; i < 3000; i++) begin
            ena = 1'($urandom_range(0, 1));
            act = ($urandom % 4) != 0;
            x = 6'($urandom_range(0, 7)); y = 6'($urandom_range(0, 7));
            valid = 1'($urandom_range(0, 1));
            waddr = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            wdata = 8'($urandom);
            tick();
        end
        valid = 0; act = 0; ena = 1;
        for (int i = 0; i < 6; i++) tick();
`ifdef OSD_VRAM_CLEAR_EN
        begin
            int n;
            chk_host = 0;
            clear = 1; tick(); clear = 0;
            chk("busy_rise", busy, 1);
            n = 0;
            while (busy === 1'b1 && n < 5000) begin tick(); n++; end
            chk("busy_cycles", n, 4096);
            chk_host = 1;
            for (int i = 0; i < 4096; i++) begin mem_m[i] = 8'h03; known_m[i] = 1; end
            tick();
            for (int i = 0; i < 40; i++) begin
                ena = 1; act = 1;
                x = 6'($urandom); y = 6'($urandom);
                tick();
            end
            act = 0; tick(); tick();
            chk_host = 0;
            clear = 1; tick(); clear = 0;
            for (int i = 0; i < 50; i++) tick();
            rst = 1; tick();
            chk("busy_reset", busy, 0);
            rst = 0; tick();
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
